// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  // Every quotient bit is set on a divide by zero; replicate to the operand width.
  localparam logic DIV_ZERO_Q_BIT = 1'b1;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, conditionally subtract.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] p_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] p_out,
  output logic             q_bit
);

  // The shifted partial remainder needs one extra bit before the compare.
  logic [WIDTH:0] p_shift;

  always_comb begin
    p_shift = {p_in, bit_in};
    q_bit   = 1'b0;
    p_out   = p_shift[WIDTH-1:0];
    if (p_shift >= {1'b0, divisor}) begin
      q_bit = 1'b1;
      p_out = p_shift[WIDTH-1:0] - divisor;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider: FSM, step counter, operand and result registers.
// Define SEQ_DIVIDER_SIGNED_EN for two's complement operands with sign fix-up on completion.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] p_r;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] p_next;
  logic             q_bit;
  logic [WIDTH-1:0] quot_next;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic             accept;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;
  assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
  assign dividend_mag = dividend;
  assign divisor_mag  = divisor;
`endif

  assign accept    = start && ((state == IDLE) || (state == DONE));
  // a_r doubles as the quotient register: dividend bits leave at the top, quotient bits enter at the bottom.
  assign quot_next = {a_r[WIDTH-2:0], q_bit};

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_in    (p_r),
    .bit_in  (a_r[WIDTH-1]),
    .divisor (divisor_r),
    .p_out   (p_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      a_r         <= '0;
      p_r         <= '0;
      divisor_r   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= {WIDTH{DIV_ZERO_Q_BIT}};
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state     <= RUN;
              busy      <= 1'b1;
              a_r       <= dividend_mag;
              divisor_r <= divisor_mag;
              p_r       <= '0;
              cnt       <= CNT_W'(WIDTH - 1);
`ifdef SEQ_DIVIDER_SIGNED_EN
              neg_q     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              neg_r     <= dividend[WIDTH-1];
`endif
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_r <= quot_next;
          p_r <= p_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            quotient    <= neg_q ? -quot_next : quot_next;
            remainder   <= neg_r ? -p_next : p_next;
`else
            quotient    <= quot_next;
            remainder   <= p_next;
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
